m31_mul_arb: RTL and testbench

Round-robin arbiter that shares one `m31_mul` instance among `N_REQ` requesters in the Poseidon2 datapath. It accepts at most one operand pair per cycle through per-requester valid/ready handshakes and registers the operands into the multiplier. It tracks requester ID and tag alongside the fixed-latency pipeline and returns each product on a shared response bus with the originating ID. It sits between round-function lanes (S-box, MDS) and the single M31 multiplier resource.

---
 rtl/m31_pkg.sv | 13 +
 rtl/m31_mul.sv | 42 ++++
 rtl/m31_mul_arb.sv | 148 ++++++++++++++
 tb/tb_m31_mul_arb.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/m31_pkg.sv
// Shared M31 field types and constants for the Poseidon2 datapath.
// MUL_LAT is the register depth of m31_mul; sideband pipelines size themselves from it.
package m31_pkg;

  localparam int unsigned M31_W = 31;

  typedef logic [M31_W-1:0] m31_t;

  localparam m31_t P_M31 = 31'h7FFF_FFFF;

  localparam int MUL_LAT = 4;

endpackage

// File: rtl/m31_mul.sv
// Four-stage pipelined multiplier modulo 2^31-1 with canonical output.
// Stages: full product, first fold, second fold, final conditional subtract.
module m31_mul import m31_pkg::*; (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [M31_W-1:0] a_i,
  input  logic [M31_W-1:0] b_i,
  output logic [M31_W-1:0] res_o
);

  logic [2*M31_W-1:0] prod_d, prod_q;
  logic [M31_W:0]     sum_d, sum_q;
  logic [M31_W:0]     fold_d, fold_q;
  logic [M31_W:0]     diff;
  logic [M31_W-1:0]   res_d, res_q;

  // 2^31 == 1 (mod P), so the high half folds onto the low half by addition.
  always_comb begin
    prod_d = {{M31_W{1'b0}}, a_i} * {{M31_W{1'b0}}, b_i};
    sum_d  = {1'b0, prod_q[M31_W-1:0]} + {1'b0, prod_q[2*M31_W-1:M31_W]};
    fold_d = {1'b0, sum_q[M31_W-1:0]} + {{M31_W{1'b0}}, sum_q[M31_W]};
    diff   = fold_q - {1'b0, P_M31};
    res_d  = (fold_q >= {1'b0, P_M31}) ? diff[M31_W-1:0] : fold_q[M31_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_q <= '0;
      sum_q  <= '0;
      fold_q <= '0;
      res_q  <= '0;
    end else begin
      prod_q <= prod_d;
      sum_q  <= sum_d;
      fold_q <= fold_d;
      res_q  <= res_d;
    end
  end

  assign res_o = res_q;

endmodule

// File: rtl/m31_mul_arb.sv
// Round-robin front end sharing one m31_mul among N_REQ requesters, with an
// id/tag sideband pipeline aligned to the multiplier latency.
module m31_mul_arb import m31_pkg::*; #(
  parameter  int unsigned N_REQ = 4,
  parameter  int unsigned TAG_W = 4,
  localparam int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en_i,
  input  logic [N_REQ-1:0]             req_valid_i,
  output logic [N_REQ-1:0]             req_ready_o,
  input  logic [N_REQ-1:0][M31_W-1:0]  req_a_i,
  input  logic [N_REQ-1:0][M31_W-1:0]  req_b_i,
  input  logic [N_REQ-1:0][TAG_W-1:0]  req_tag_i,
  output logic                         rsp_valid_o,
  output logic [ID_W-1:0]              rsp_id_o,
  output logic [TAG_W-1:0]             rsp_tag_o,
  output logic [M31_W-1:0]             rsp_res_o,
  output logic [2:0]                   inflight_o,
  output logic                         idle_o
);

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic [ID_W-1:0]  cand;
  logic             gnt_found;
  logic             hs;
  int unsigned      idx;

  // Search upward from ptr with wrap-around; first valid index wins.
  always_comb begin
    gnt       = '0;
    gnt_id    = '0;
    gnt_found = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx = {{(32 - ID_W){1'b0}}, ptr_q} + i;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      cand = idx[ID_W-1:0];
      if (!gnt_found && req_valid_i[cand]) begin
        gnt[cand] = 1'b1;
        gnt_id    = cand;
        gnt_found = 1'b1;
      end
    end
  end

  assign req_ready_o = (en_i && rst_n) ? gnt : '0;
  assign hs          = en_i & rst_n & gnt_found;

  always_comb begin
    ptr_d = ptr_q;
    if (hs) begin
      ptr_d = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Issue registers: operands hold when idle so the multiplier input is stable.
  logic             iss_v_q;
  logic [M31_W-1:0] iss_a_q, iss_b_q;
  logic [TAG_W-1:0] iss_tag_q;
  logic [ID_W-1:0]  iss_id_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      iss_v_q   <= 1'b0;
      iss_a_q   <= '0;
      iss_b_q   <= '0;
      iss_tag_q <= '0;
      iss_id_q  <= '0;
    end else begin
      iss_v_q <= hs;
      if (hs) begin
        iss_a_q   <= req_a_i[gnt_id];
        iss_b_q   <= req_b_i[gnt_id];
        iss_tag_q <= req_tag_i[gnt_id];
        iss_id_q  <= gnt_id;
      end
    end
  end

  logic [M31_W-1:0] mul_res;

  m31_mul u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .a_i   (iss_a_q),
    .b_i   (iss_b_q),
    .res_o (mul_res)
  );

  logic [MUL_LAT-1:0]            sb_v_q;
  logic [MUL_LAT-1:0][ID_W-1:0]  sb_id_q;
  logic [MUL_LAT-1:0][TAG_W-1:0] sb_tag_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb_v_q   <= '0;
      sb_id_q  <= '0;
      sb_tag_q <= '0;
    end else begin
      sb_v_q   <= {sb_v_q[MUL_LAT-2:0], iss_v_q};
      sb_id_q  <= {sb_id_q[MUL_LAT-2:0], iss_id_q};
      sb_tag_q <= {sb_tag_q[MUL_LAT-2:0], iss_tag_q};
    end
  end

  assign rsp_valid_o = sb_v_q[MUL_LAT-1];
  assign rsp_id_o    = sb_id_q[MUL_LAT-1];
  assign rsp_tag_o   = sb_tag_q[MUL_LAT-1];
  assign rsp_res_o   = mul_res;

  logic [2:0] inflight_q, inflight_d;

  always_comb begin
    inflight_d = inflight_q;
    case ({hs, rsp_valid_o})
      2'b10:   inflight_d = inflight_q + 3'd1;
      2'b01:   inflight_d = inflight_q - 3'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_q <= '0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  assign inflight_o = inflight_q;
  assign idle_o     = (inflight_q == 3'd0);

endmodule

// File: tb/tb_m31_mul_arb.sv
// Self-checking bench for m31_mul_arb: a queue-based reference model predicts
// grants, responses and occupancy from the arbitration and latency rules.
module tb_m31_mul_arb;

  localparam int N  = 4;
  localparam int TW = 4;
  localparam longint unsigned PM = 64'h7FFF_FFFF;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic [N-1:0]          req_valid;
  logic [N-1:0][30:0]    req_a, req_b;
  logic [N-1:0][TW-1:0]  req_tag;
  logic [N-1:0]          req_ready;
  logic                  rsp_valid;
  logic [1:0]            rsp_id;
  logic [TW-1:0]         rsp_tag;
  logic [30:0]           rsp_res;
  logic [2:0]            inflight;
  logic                  idle;

  always #5 clk = ~clk;

  m31_mul_arb #(
    .N_REQ (N),
    .TAG_W (TW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (en),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_tag_i   (req_tag),
    .rsp_valid_o (rsp_valid),
    .rsp_id_o    (rsp_id),
    .rsp_tag_o   (rsp_tag),
    .rsp_res_o   (rsp_res),
    .inflight_o  (inflight),
    .idle_o      (idle)
  );

  typedef struct {
    logic [1:0]    id;
    logic [TW-1:0] tag;
    logic [30:0]   res;
    int            due;
  } rsp_t;

  rsp_t q[$];
  int   m_ptr = 0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [N-1:0] o_ready, e_ready;
  logic         o_rv, e_rv;
  logic [36:0]  o_rsp, e_rsp;
  logic [2:0]   o_infl, e_infl;
  logic         o_idle, e_idle;

  function automatic logic [30:0] mulmod(logic [30:0] a, logic [30:0] b);
    longint unsigned p;
    p = a;
    p = p * b;
    return 31'(p % PM);
  endfunction

  function automatic logic [30:0] rand_op();
    case ($urandom_range(0, 7))
      0:       return 31'd0;
      1:       return 31'h7FFF_FFFE;
      default: return 31'($urandom_range(0, 32'h7FFF_FFFE));
    endcase
  endfunction

  function automatic logic [N-1:0] model_grant();
    logic [N-1:0] g;
    logic         found;
    g = '0;
    found = 1'b0;
    if (en && rst_n) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (!found && req_valid[k]) begin
          g[k] = 1'b1;
          found = 1'b1;
        end
      end
    end
    return g;
  endfunction

  task automatic new_req(input int i);
    req_a[i]   = rand_op();
    req_b[i]   = rand_op();
    req_tag[i] = TW'($urandom);
  endtask

  // One clock cycle: sample DUT and model on the falling edge, advance model on the rising edge.
  task automatic tick();
    @(negedge clk);
    o_ready = req_ready;
    o_rv    = rsp_valid;
    o_rsp   = {rsp_id, rsp_tag, rsp_res};
    o_infl  = inflight;
    o_idle  = idle;
    e_ready = model_grant();
    e_rv    = (q.size() > 0) && (q[0].due == cyc);
    e_rsp   = e_rv ? {q[0].id, q[0].tag, q[0].res} : '0;
    e_infl  = 3'(q.size());
    e_idle  = (q.size() == 0);
    @(posedge clk);
    if (e_rv) void'(q.pop_front());
    for (int i = 0; i < N; i++) begin
      if (e_ready[i]) begin
        q.push_back('{id: 2'(i), tag: req_tag[i], res: mulmod(req_a[i], req_b[i]),
                      due: cyc + 5});
        m_ptr = (i + 1) % N;
      end
    end
    if (!rst_n) begin
      q.delete();
      m_ptr = 0;
    end
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    req_valid = '1;
    for (int i = 0; i < N; i++) new_req(i);
    tick();
    tick();
    checks++;
    if (o_ready !== '0) begin
      errors++; $display("FAIL reset_ready got=%b exp=0000", o_ready);
    end
    checks++;
    if ({o_rv, o_rsp} !== 38'd0) begin
      errors++; $display("FAIL reset_rsp got=%b/%h exp=0/0", o_rv, o_rsp);
    end
    checks++;
    if (o_infl !== 3'd0 || o_idle !== 1'b1) begin
      errors++; $display("FAIL reset_occ got=%0d/%b exp=0/1", o_infl, o_idle);
    end
    req_valid = '0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int k;
    req_a[0] = 31'd2; req_b[0] = 31'd3; req_tag[0] = 4'd5;
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    k = 0;
    while (k < 10) begin
      tick();
      k++;
      checks++;
      if (o_rv !== e_rv || (e_rv && o_rsp !== e_rsp)) begin
        errors++; $display("FAIL single_model got=%b/%h exp=%b/%h", o_rv, o_rsp, e_rv, e_rsp);
      end
      if (o_rv === 1'b1) break;
    end
    checks++;
    if (k != 5) begin
      errors++; $display("FAIL single_latency got=%0d exp=5", k);
    end
    checks++;
    if (o_rsp !== {2'd0, 4'd5, 31'd6}) begin
      errors++; $display("FAIL single_rsp got=%h exp=%h", o_rsp, {2'd0, 4'd5, 31'd6});
    end
    tick();
    checks++;
    if (o_infl !== 3'd0 || o_idle !== 1'b1) begin
      errors++; $display("FAIL single_drain got=%0d/%b exp=0/1", o_infl, o_idle);
    end
  endtask

  task automatic test_corners();
    logic [30:0] ca[3];
    logic [30:0] cb[3];
    logic [30:0] cr[3];
    int n;
    ca = '{31'h7FFF_FFFE, 31'h4000_0000, 31'd0};
    cb = '{31'h7FFF_FFFE, 31'd2,         31'h7FFF_FFFE};
    cr = '{31'd1,         31'd1,         31'd0};
    for (int i = 0; i < 3; i++) begin
      req_valid = 4'b0001; req_a[0] = ca[i]; req_b[0] = cb[i]; req_tag[0] = 4'(i);
      tick();
    end
    req_valid = '0;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (o_rv !== e_rv || (e_rv && o_rsp !== e_rsp)) begin
        errors++; $display("FAIL corner_model got=%b/%h exp=%b/%h", o_rv, o_rsp, e_rv, e_rsp);
      end
      if (o_rv === 1'b1 && n < 3) begin
        checks++;
        if (o_rsp[30:0] !== cr[n]) begin
          errors++; $display("FAIL corner_res%0d got=%h exp=%h", n, o_rsp[30:0], cr[n]);
        end
        n++;
      end
    end
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL corner_count got=%0d exp=3", n);
    end
  endtask

  task automatic test_rotation();
    int start;
    int max_infl;
    start = m_ptr;
    max_infl = 0;
    req_valid = '1;
    for (int i = 0; i < N; i++) new_req(i);
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if (o_ready !== N'(1 << ((start + c) % N))) begin
        errors++; $display("FAIL rot_grant cyc=%0d got=%b exp=%b", c, o_ready,
                           N'(1 << ((start + c) % N)));
      end
      checks++;
      if (o_rv !== e_rv || (e_rv && o_rsp !== e_rsp)) begin
        errors++; $display("FAIL rot_rsp got=%b/%h exp=%b/%h", o_rv, o_rsp, e_rv, e_rsp);
      end
      checks++;
      if (o_infl !== e_infl) begin
        errors++; $display("FAIL rot_infl got=%0d exp=%0d", o_infl, e_infl);
      end
      if (int'(o_infl) > max_infl) max_infl = int'(o_infl);
      for (int i = 0; i < N; i++) if (e_ready[i]) new_req(i);
    end
    checks++;
    if (max_infl != 5) begin
      errors++; $display("FAIL rot_saturate got=%0d exp=5", max_infl);
    end
    req_valid = '0;
    for (int c = 0; c < 6; c++) tick();
  endtask

  task automatic test_pair();
    logic [N-1:0] vpat[7];
    int           gexp[7];
    vpat = '{4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b1010, 4'b0010, 4'b1010};
    gexp = '{1, 3, 1, 3, 1, 1, 3};
    rst_n = 1'b0;
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 7; c++) begin
      req_valid = vpat[c];
      tick();
      checks++;
      if (o_ready !== N'(1 << gexp[c]) || o_ready !== e_ready) begin
        errors++; $display("FAIL pair_grant cyc=%0d got=%b exp=%b", c, o_ready, N'(1 << gexp[c]));
      end
      for (int i = 0; i < N; i++) if (e_ready[i]) new_req(i);
    end
    req_valid = '0;
    for (int c = 0; c < 7; c++) begin
      tick();
      checks++;
      if (o_rv !== e_rv || (e_rv && o_rsp !== e_rsp)) begin
        errors++; $display("FAIL pair_rsp got=%b/%h exp=%b/%h", o_rv, o_rsp, e_rv, e_rsp);
      end
    end
  endtask

  task automatic test_enable();
    int saved;
    req_valid = '1;
    en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int i = 0; i < N; i++) if (e_ready[i]) new_req(i);
    end
    en = 1'b0;
    saved = m_ptr;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (o_ready !== '0) begin
        errors++; $display("FAIL en_ready cyc=%0d got=%b exp=0000", c, o_ready);
      end
      checks++;
      if (o_rv !== e_rv || (e_rv && o_rsp !== e_rsp) || o_idle !== e_idle) begin
        errors++; $display("FAIL en_drain got=%b/%h/%b exp=%b/%h/%b", o_rv, o_rsp, o_idle,
                           e_rv, e_rsp, e_idle);
      end
    end
    checks++;
    if (o_idle !== 1'b1) begin
      errors++; $display("FAIL en_idle got=%b exp=1", o_idle);
    end
    en = 1'b1;
    tick();
    checks++;
    if (o_ready !== N'(1 << saved)) begin
      errors++; $display("FAIL en_resume got=%b exp=%b", o_ready, N'(1 << saved));
    end
    req_valid = '0;
    for (int c = 0; c < 6; c++) tick();
  endtask

  task automatic test_mid_reset();
    int k;
    req_valid = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      new_req(0);
      tick();
    end
    req_valid = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (o_rv !== 1'b0 || o_infl !== 3'd0) begin
        errors++; $display("FAIL rst_quiet cyc=%0d got=%b/%0d exp=0/0", c, o_rv, o_infl);
      end
    end
    req_valid = '1;
    for (int i = 0; i < N; i++) new_req(i);
    tick();
    checks++;
    if (o_ready !== 4'b0001) begin
      errors++; $display("FAIL rst_ptr got=%b exp=0001", o_ready);
    end
    req_valid = '0;
    k = 0;
    while (k < 10) begin
      tick();
      k++;
      if (o_rv === 1'b1) break;
    end
    checks++;
    if (k != 5 || o_rsp !== e_rsp) begin
      errors++; $display("FAIL rst_first got=%0d/%h exp=5/%h", k, o_rsp, e_rsp);
    end
    for (int c = 0; c < 3; c++) tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i]) begin
          req_valid[i] = ($urandom_range(0, 2) == 0);
          if (req_valid[i]) new_req(i);
        end else if ($urandom_range(0, 15) == 0) begin
          new_req(i);
        end
      end
      tick();
      checks++;
      if (o_ready !== e_ready) begin
        errors++; $display("FAIL rnd_grant cyc=%0d got=%b exp=%b", c, o_ready, e_ready);
      end
      checks++;
      if (o_rv !== e_rv || (e_rv && o_rsp !== e_rsp)) begin
        errors++; $display("FAIL rnd_rsp cyc=%0d got=%b/%h exp=%b/%h", c, o_rv, o_rsp, e_rv, e_rsp);
      end
      checks++;
      if (o_infl !== e_infl || o_idle !== e_idle) begin
        errors++; $display("FAIL rnd_occ cyc=%0d got=%0d/%b exp=%0d/%b", c, o_infl, o_idle,
                           e_infl, e_idle);
      end
      for (int i = 0; i < N; i++) if (e_ready[i]) req_valid[i] = 1'b0;
    end
    req_valid = '0;
    for (int c = 0; c < 7; c++) tick();
    checks++;
    if (o_idle !== 1'b1 || q.size() != 0) begin
      errors++; $display("FAIL rnd_final got=%b exp=1", o_idle);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_tag = '0;
    test_reset();
    test_single();
    test_corners();
    test_rotation();
    test_pair();
    test_enable();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
